// File: rtl/bram_w_sched.sv
// bram_w_sched: single-port weight BRAM scheduler (credit-FIFO burst reads, word writes); BRAM_SCHED_PERF_EN adds perf counters
module bram_w_sched #(
  parameter int DEPTH     = 4,
  parameter int LEN_W     = 16,
  parameter int MEM_WORDS = 3001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  input  logic [31:0]      rd_base,
  input  logic [LEN_W-1:0] rd_len,
  output logic             rd_busy,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_done,
  input  logic             wr_valid,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  output logic             wr_ready,
  output logic             bram_en,
  output logic [3:0]       bram_wen,
  output logic [31:0]      bram_addr,
  output logic [31:0]      bram_din,
  input  logic [31:0]      bram_dout
`ifdef BRAM_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_rd_words,
  output logic [31:0]      perf_wr_words,
  output logic [31:0]      perf_conflict
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [29:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wp_q, rp_q;
  logic [31:0] fifo_q [DEPTH];
  logic infl_q, rr_q, rr_d;
  logic rd_elig, contest, gr_rd, gr_wr, push, pop, start;
  logic beyond_mem_unused;
  always_comb begin
    start   = state_q == IDLE && rd_req;
    rd_elig = state_q == BURST && (cnt_q + CW'(infl_q)) < CW'(DEPTH);
    contest = rd_elig && wr_valid;
    gr_rd   = rd_elig && (!wr_valid || rr_q);
    gr_wr   = wr_valid && !gr_rd;
    push    = infl_q;
    pop     = rd_valid && rd_ready;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    ptr_d   = start ? rd_base[31:2] : ptr_q + 30'(gr_rd);
    rem_d   = start ? rd_len : rem_q - LEN_W'(gr_rd);
    rr_d    = contest ? !gr_rd : rr_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = rd_req ? (rd_len == '0 ? DONE : BURST) : IDLE;
      BURST:   state_d = gr_rd && rem_q == LEN_W'(1) ? DRAIN : BURST;
      // Leave DRAIN in the same cycle the last word is popped so rd_done follows it directly.
      DRAIN:   state_d = !infl_q && (cnt_q == '0 || (cnt_q == CW'(1) && pop)) ? DONE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  assign rd_busy   = state_q != IDLE;
  assign rd_done   = state_q == DONE;
  assign rd_valid  = cnt_q != '0;
  assign rd_data   = fifo_q[rp_q];
  assign wr_ready  = gr_wr;
  assign bram_en   = gr_rd || gr_wr;
  assign bram_wen  = {4{gr_wr}};
  assign bram_addr = gr_wr ? wr_addr : {ptr_q, 2'b00};
  assign bram_din  = wr_data;
  assign beyond_mem_unused = {2'b00, ptr_q} >= 32'(MEM_WORDS) || |rd_base[1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      infl_q  <= 1'b0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      wp_q    <= wp_q + AW'(push);
      rp_q    <= rp_q + AW'(pop);
      infl_q  <= gr_rd;
      rr_q    <= rr_d;
    end
  always_ff @(posedge clk)
    if (push) fifo_q[wp_q] <= bram_dout;
`ifdef BRAM_SCHED_PERF_EN
  logic [31:0] prd_q, pwr_q, pcf_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prd_q <= '0;
      pwr_q <= '0;
      pcf_q <= '0;
    end else begin
      prd_q <= prd_q + 32'(pop && !(&prd_q));
      pwr_q <= pwr_q + 32'(gr_wr && !(&pwr_q));
      pcf_q <= pcf_q + 32'(contest && !(&pcf_q));
    end
  assign perf_rd_words = prd_q;
  assign perf_wr_words = pwr_q;
  assign perf_conflict = pcf_q;
`endif
endmodule

// File: tb/tb_bram_w_sched.sv
// tb_bram_w_sched: directed bench with a BRAM model, golden memory image and per-cycle stream checker
module tb_bram_w_sched;
  localparam int DEPTH = 4;
  logic clk, rst, rd_req, rd_busy, rd_valid, rd_ready, rd_done;
  logic wr_valid, wr_ready, bram_en;
  logic [31:0] rd_base, rd_data, wr_addr, wr_data, bram_addr, bram_din, bram_dout;
  logic [15:0] rd_len;
  logic [3:0] bram_wen;
`ifdef BRAM_SCHED_PERF_EN
  logic [31:0] perf_rd_words, perf_wr_words, perf_conflict;
`endif

  bram_w_sched #(.DEPTH(DEPTH), .LEN_W(16), .MEM_WORDS(3001)) dut (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_done(rd_done), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
`ifdef BRAM_SCHED_PERF_EN
    , .perf_rd_words(perf_rd_words), .perf_wr_words(perf_wr_words), .perf_conflict(perf_conflict)
`endif
  );

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int n_issue, n_pop, n_done = 0, n_busy, first_issue, first_valid, last_issue, last_pop, done_cyc, req_cyc;
  logic [31:0] mem [0:4095];
  logic [31:0] gold [0:4095];
  logic [31:0] exp_addr [$];
  logic [31:0] exp_data [$];
  logic [31:0] iss [$];
  logic [31:0] popped [$];
  bit gseq [$];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Environment BRAM: one-cycle registered read, write-only cycles leave dout unchanged.
  initial for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE0000 | 32'(i);
  always @(posedge clk)
    if (bram_en) begin
      if (bram_wen != 4'h0) mem[bram_addr[13:2]] <= bram_din;
      else bram_dout <= mem[bram_addr[13:2]];
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  always @(negedge clk)
    if (!rst) begin
      if (bram_en && bram_wen == 4'h0) begin
        if (exp_addr.size() == 0) chk("spurious_read", bram_addr, 32'hFFFFFFFF);
        else chk("rd_addr", bram_addr, exp_addr.pop_front());
        chk("rd_slot_no_wr_ready", 32'(wr_ready), 0);
        iss.push_back(bram_addr);
        gseq.push_back(1'b1);
        n_issue++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
        chk("credit", 32'(n_issue - n_pop <= DEPTH), 1);
      end
      if (bram_en && bram_wen != 4'h0) begin
        chk("wr_wen", 32'(bram_wen), 32'hF);
        chk("wr_addr", bram_addr, wr_addr);
        chk("wr_din", bram_din, wr_data);
        chk("wr_ready", 32'({wr_ready, wr_valid}), 32'h3);
        gseq.push_back(1'b0);
      end
      if (wr_ready && !bram_en) chk("wr_ready_without_en", 32'(bram_en), 1);
      if (rd_valid && first_valid < 0) first_valid = cyc;
      if (rd_valid && rd_ready) begin
        if (exp_data.size() == 0) chk("spurious_pop", rd_data, 32'hFFFFFFFF);
        else chk("rd_data", rd_data, exp_data.pop_front());
        popped.push_back(rd_data);
        n_pop++;
        last_pop = cyc;
      end
      if (rd_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (rd_busy) n_busy++;
    end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_burst(input logic [31:0] base, input int len);
    rd_req = 1;
    rd_base = base;
    rd_len = 16'(len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back(base + 32'(4 * i));
      exp_data.push_back(gold[(int'(base[13:2]) + i) % 4096]);
    end
    first_issue = -1;
    first_valid = -1;
    n_issue = 0;
    n_pop = 0;
    n_busy = 0;
    iss.delete();
    popped.delete();
    gseq.delete();
    req_cyc = cyc;
    step(1);
    rd_req = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int start = n_done;
    int k = 0;
    while (n_done == start && k < budget) begin
      step(1);
      k++;
    end
    chk({nm, "_done_in_time"}, 32'(n_done != start), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [14:0] pat;
    for (int i = 0; i < 4096; i++) gold[i] = 32'hC0DE0000 | 32'(i);
    rst = 1; rd_req = 0; rd_base = 0; rd_len = 0; rd_ready = 1;
    wr_valid = 0; wr_addr = 0; wr_data = 0;
    step(2);
    chk("reset_outputs", 32'({rd_busy, rd_valid, rd_done, bram_en, wr_ready}), 0);
    chk("reset_wen", 32'(bram_wen), 0);
    @(posedge clk);
    #3 rst = 0;
    step(1);

    // Full-rate burst
    start_burst(32'h10, 4);
    wait_done("burst4", 30);
    chk("b1_first_issue", first_issue, req_cyc + 1);
    chk("b1_addr0", iss[0], 32'h10);
    chk("b1_addr1", iss[1], 32'h14);
    chk("b1_addr2", iss[2], 32'h18);
    chk("b1_addr3", iss[3], 32'h1C);
    chk("b1_consecutive", last_issue - first_issue, 3);
    chk("b1_valid_latency", first_valid, first_issue + 2);
    chk("b1_word0", popped[0], 32'hC0DE0004);
    chk("b1_word3", popped[3], 32'hC0DE0007);
    chk("b1_done_after_pop", done_cyc, last_pop + 1);
    chk("b1_pops", n_pop, 4);

    // Stalled consumer: credits cap issues at DEPTH
    rd_ready = 0;
    start_burst(32'h10, 8);
    step(10);
    chk("b2_stall_issues", n_issue, DEPTH);
    chk("b2_stall_valid", 32'(rd_valid), 1);
    rd_ready = 1;
    wait_done("stall", 60);
    chk("b2_pops", n_pop, 8);
    chk("b2_all_data", exp_data.size(), 0);
    chk("b2_word7", popped[7], 32'hC0DE000B);

    // Contested port: round-robin, read first
    wr_valid = 1; wr_addr = 32'h100; wr_data = 32'h12345678;
    gold[64] = 32'h12345678;
    start_burst(32'h40, 8);
    wait_done("contest", 80);
    wr_valid = 0;
    k = -1;
    foreach (gseq[i]) if (gseq[i] && k < 0) k = i;
    pat = '0;
    if (k >= 0 && gseq.size() >= k + 15) for (int j = 0; j < 15; j++) pat[14-j] = gseq[k+j];
    chk("b3_rr_pattern", 32'(pat), 32'h5555);
    chk("b3_pops", n_pop, 8);
    chk("b3_word0", popped[0], 32'hC0DE0010);

    // Write then read back the same address
    wr_valid = 1; wr_addr = 32'h20; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("b4_idle_write_grant", 32'(wr_ready), 1);
    @(posedge clk);
    #1 wr_valid = 0;
    gold[8] = 32'hDEADBEEF;
    start_burst(32'h20, 1);
    wait_done("rdback", 20);
    chk("b4_readback", popped[0], 32'hDEADBEEF);

    // Zero-length burst
    start_burst(32'h0, 0);
    wait_done("len0", 10);
    step(1);
    chk("b5_no_issue", n_issue, 0);
    chk("b5_done_cycle", done_cyc, req_cyc + 1);
    chk("b5_busy_cycles", n_busy, 1);

    // Asynchronous reset mid-burst
    rd_ready = 0;
    start_burst(32'h10, 8);
    step(3);
    chk("b6_pre_reset_valid", 32'(rd_valid), 1);
    #2 rst = 1;
    #1;
    chk("b6_async_reset", 32'({rd_busy, rd_valid, rd_done, bram_en}), 0);
    exp_addr.delete();
    exp_data.delete();
    @(posedge clk);
    #3 rst = 0;
    step(1);
    wr_valid = 1; wr_addr = 32'h200; wr_data = 32'h55AA55AA;
    gold[128] = 32'h55AA55AA;
    rd_ready = 1;
    start_burst(32'h30, 3);
    wait_done("post_reset", 40);
    wr_valid = 0;
    chk("b6_rr_reset_read_first", first_issue, req_cyc + 1);
    chk("b6_pops", n_pop, 3);
    chk("b6_word0", popped[0], 32'hC0DE000C);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
